// File: rtl/lifo_fifo_buffer_if.sv
// Bus bundle for lifo_fifo_buffer: producer/consumer requests and buffer status.
// master: drives mode/clear/write/datain/read and observes status and read data.
// slave:  the buffer itself; almost_full exists only with LIFO_FIFO_BUFFER_WATERMARK_EN.
interface lifo_fifo_buffer_if #(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 10
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              mode;
  logic              clear;
  logic              write;
  logic [DATA_W-1:0] datain;
  logic              read;
  logic [DATA_W-1:0] dataout;
  logic              val;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              mode_act;
  logic              overflow;
  logic              underflow;
`ifdef LIFO_FIFO_BUFFER_WATERMARK_EN
  logic              almost_full;
`endif

  modport master (
    output mode, clear, write, datain, read,
    input  dataout, val, full, empty, count, mode_act, overflow, underflow
`ifdef LIFO_FIFO_BUFFER_WATERMARK_EN
    , input almost_full
`endif
  );

  modport slave (
    input  mode, clear, write, datain, read,
    output dataout, val, full, empty, count, mode_act, overflow, underflow
`ifdef LIFO_FIFO_BUFFER_WATERMARK_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// Purpose: DEPTH-entry scratch buffer, runtime-selectable LIFO/FIFO order over one memory.
// Latency: read data and val registered, one cycle after the accepted read.
// Backpressure: none; writes when full are dropped (overflow), reads when empty flag underflow.
// Ports: clock, reset (async active-low), bus (lifo_fifo_buffer_if.slave): mode, clear,
//   write, datain, read in; dataout, val, full, empty, count, mode_act, overflow, underflow out.
// Optional: define LIFO_FIFO_BUFFER_WATERMARK_EN for parameter AFULL_LVL and output almost_full.
module lifo_fifo_buffer #(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 10
`ifdef LIFO_FIFO_BUFFER_WATERMARK_EN
  , parameter int AFULL_LVL = DEPTH - 1
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  lifo_fifo_buffer_if.slave     bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              val_q, val_d;
  logic              mode_act_q, mode_act_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic              is_full, is_empty;
  logic [PTR_W-1:0]  push_idx, top_idx, wr_ptr_nxt, rd_ptr_nxt;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // Stack top: push lands at mem[count], pop/replace uses mem[count-1].
  // Truncation is safe: push_idx is only used when not full, top_idx only when not empty.
  assign push_idx = PTR_W'(count_q);
  assign top_idx  = PTR_W'(count_q - CNT_W'(1));

  // Queue pointers wrap explicitly so DEPTH need not be a power of two.
  assign wr_ptr_nxt = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
  assign rd_ptr_nxt = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dataout_d   = dataout_q;
    val_d       = 1'b0;
    mode_act_d  = mode_act_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;

    if (bus.clear) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      mode_act_d  = bus.mode;
    end else begin
      // Order may only change while the buffer is empty and quiet, so
      // stored entries are never reinterpreted under the other order.
      if (is_empty && !bus.read && !bus.write) begin
        mode_act_d = bus.mode;
      end

      if (bus.write && bus.read) begin
        val_d = 1'b1;
        if (is_empty) begin
          dataout_d = bus.datain;   // pass-through, nothing stored
        end else if (mode_act_q) begin
          dataout_d = mem[top_idx];
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end else begin
          // Also legal when full: the read frees the slot the write consumes.
          dataout_d = mem[rd_ptr_q];
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          wr_ptr_d  = wr_ptr_nxt;
          rd_ptr_d  = rd_ptr_nxt;
        end
      end else if (bus.write) begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = mode_act_q ? push_idx : wr_ptr_q;
          count_d   = count_q + CNT_W'(1);
          if (!mode_act_q) wr_ptr_d = wr_ptr_nxt;
        end
      end else if (bus.read) begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          dataout_d = mode_act_q ? mem[top_idx] : mem[rd_ptr_q];
          val_d     = 1'b1;
          count_d   = count_q - CNT_W'(1);
          if (!mode_act_q) rd_ptr_d = rd_ptr_nxt;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dataout_q   <= '0;
      val_q       <= 1'b0;
      mode_act_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dataout_q   <= dataout_d;
      val_q       <= val_d;
      mode_act_q  <= mode_act_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array carries no reset; contents are meaningless once count is 0.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= bus.datain;
  end

  assign bus.dataout   = dataout_q;
  assign bus.val       = val_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.count     = count_q;
  assign bus.mode_act  = mode_act_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`ifdef LIFO_FIFO_BUFFER_WATERMARK_EN
  assign bus.almost_full = (count_q >= CNT_W'(AFULL_LVL));
`endif
endmodule
